m68k_bus_slave: RTL and testbench
=================================

# m68k_bus_slave

Synchronous bus-slave front end that consumes 68010 asynchronous bus cycles (AS/UDS/LDS/RW/FC/address/data) and turns them into single-cycle-qualified memory requests on a valid/ack interface. It generates DTACK for completed cycles and BERR for timed-out ones. It sits directly downstream of the CPU pins, in the C100 domain, and in front of the RAM/peripheral controllers.

## Interface
Parameters:
- TIMEOUT — 255 — C100 cycles in REQ without mem_ack before BERR is asserted.

Ports:
- C100  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- as_n, rw_n, uds_n, lds_n  in  1 each  CPU strobes, asynchronous. rw_n = 0 means write.
- fc  in  3  CPU function code.
- addr  in  23  CPU A[23:1].
- d_in  in  16  CPU data for writes.
- d_out  out  16  read data to the CPU pins.
- d_oe  out  1  data pin output enable.
- dtack_n  out  1  data acknowledge to the CPU.
- berr_n  out  1  bus error to the CPU.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  23  latched A[23:1].
- mem_be  out  2  {upper, lower} byte enables.
- mem_fc  out  3  latched function code.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  completes the request.

## Operation
- as_n, uds_n, lds_n and rw_n each pass through a 2-FF synchronizer (as_s, uds_s, lds_s, rw_s). addr, fc and d_in are sampled raw; the CPU holds them stable before the strobes are seen.
- IDLE:
  - On as_s=0 with uds_s=0 or lds_s=0, and fc≠3'b111: latch mem_addr, mem_fc, mem_we=~rw_s, mem_be={~uds_s,~lds_s}, mem_wdata=d_in. Set mem_req=1. Clear the timeout counter. Go to REQ.
  - On as_s=0 with fc=3'b111 (interrupt acknowledge): go to IGNORE. IACK is serviced elsewhere via VPA.
  - On as_s=0 with no data strobe low: stay in IDLE (address-only phase).
- REQ:
  - mem_* outputs are held constant.
  - When mem_ack=1 is sampled: mem_req←0, d_out←mem_rdata if read, d_oe←~mem_we, dtack_n←0. Go to DONE.
  - Otherwise the counter increments. When counter = TIMEOUT-1 with no ack: mem_req←0, berr_n←0. Go to DONE.
- DONE: hold dtack_n, berr_n, d_oe and d_out until as_s=1. On that edge: dtack_n←1, berr_n←1, d_oe←0. Go to IDLE.
- IGNORE: wait for as_s=1, then go to IDLE. No outputs change.
- mem_ack is ignored outside REQ. The controller must not ack once mem_req has dropped, including after a timeout.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr/mem_fc/mem_wdata/d_out 0, d_oe 0, dtack_n 1, berr_n 1, counter 0, synchronizers 1 (negated).
- Reset mid-cycle: all outputs return to reset values on the next edge. A pending mem_req is abandoned, and the controller must tolerate the dropped request.
- The timeout counter is 8 bits wide. TIMEOUT must be ≤ 256.

## Timing
- Request latency: as_n and a data strobe falling before edge k gives mem_req=1 after edge k+2.
- Strobes arriving later than as_n delay mem_req to 2 edges after the later strobe.
- Ack latency: mem_ack sampled high at edge m gives dtack_n=0, d_out and d_oe valid after edge m. mem_req=0 after the same edge.
- Minimum REQ occupancy is 1 cycle: mem_ack may already be high on the first REQ edge.
- Release: as_n rising before edge n gives dtack_n=1 and d_oe=0 after edge n+2.
- Back-to-back cycles: a new request can only start from IDLE. as_n must be seen high for at least one synchronized sample between cycles.
- Timeout: berr_n falls TIMEOUT edges after mem_req rose.

## Structure
- Package m68k_bus_pkg holds:
  - state enum {IDLE, REQ, DONE, IGNORE};
  - FC_IACK = 3'b111;
  - default TIMEOUT.
- Sub-module m68k_sync: a parameterized-width 2-FF synchronizer, reset to 1, instantiated once for the 4 strobes.
- Everything else is one FSM module.

## Test plan
- Word read, addr 0x001000, fc=5, mem_ack after 3 cycles with rdata 0xBEEF: mem_addr=0x000800, mem_be=2'b11, mem_we=0, dtack_n=0, d_out=0xBEEF, d_oe=1. All release 2 edges after as_n rises.
- Lower-byte write, addr 0x002001, lds only, d_in 0x00A5: mem_we=1, mem_be=2'b01, mem_wdata=0x00A5, d_oe stays 0, dtack_n pulses low.
- No ack with TIMEOUT=16: berr_n=0 exactly 16 edges after mem_req rose, mem_req=0, dtack_n stays 1. A late mem_ack is ignored.
- IACK cycle, fc=7: mem_req, dtack_n and berr_n never assert. The FSM returns to IDLE after as_n rises.
- reset=1 for one cycle while in REQ: next edge gives mem_req=0, dtack_n=1, state IDLE. A subsequent read completes normally.
- Two back-to-back reads (0x000100, 0x000102) with as_n high for 2 C100 cycles between them: two distinct mem_req pulses and two DTACK assertions, with correct data for each.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68010 bus-slave front end.
package m68k_bus_pkg;

  // Bus-cycle controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DONE   = 2'd2,
    IGNORE = 2'd3
  } state_e;

  // Function code of an interrupt-acknowledge cycle; these are answered via VPA elsewhere.
  localparam logic [2:0] FC_IACK = 3'b111;

  // Default number of C100 cycles a request may wait for mem_ack before BERR.
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of the timeout counter; limits TIMEOUT to at most 256.
  localparam int CNT_W = 8;

  // Active-high {upper, lower} byte enables from the synchronized active-low strobes.
  function automatic logic [1:0] byte_enables(input logic uds_s, input logic lds_s);
    return {~uds_s, ~lds_s};
  endfunction

endpackage

// File: rtl/m68k_bus_slave_if.sv
// CPU pin side and memory-request side of the bus slave, bundled together.
interface m68k_bus_slave_if;

  // CPU pins
  logic        as_n;
  logic        rw_n;
  logic        uds_n;
  logic        lds_n;
  logic [2:0]  fc;
  logic [22:0] addr;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        d_oe;
  logic        dtack_n;
  logic        berr_n;

  // Memory request channel
  logic        mem_req;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [2:0]  mem_fc;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  // The slave answers the CPU and issues requests to memory.
  modport slave (
    input  as_n, rw_n, uds_n, lds_n, fc, addr, d_in,
    output d_out, d_oe, dtack_n, berr_n,
    output mem_req, mem_we, mem_addr, mem_be, mem_fc, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // The master drives the CPU pins and plays the memory controller.
  modport master (
    output as_n, rw_n, uds_n, lds_n, fc, addr, d_in,
    input  d_out, d_oe, dtack_n, berr_n,
    input  mem_req, mem_we, mem_addr, mem_be, mem_fc, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/m68k_sync.sv
// Two-flop synchronizer for active-low CPU strobes; resets to the negated (1) level.
module m68k_sync #(
  parameter int WIDTH = 1
) (
  input  logic             C100,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the asynchronous input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Stage registers; reset puts every strobe in its inactive state.
  always_ff @(posedge C100) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/m68k_bus_slave.sv
// 68010 asynchronous bus cycles in, single valid/ack memory requests out.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no cycle in progress; waiting for AS with a data strobe
// REQ    | mem_req held high, waiting for mem_ack or the timeout
// DONE   | DTACK or BERR (plus read data) held until AS is negated
// IGNORE | interrupt-acknowledge cycle; waiting for AS to be negated
module m68k_bus_slave
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             C100,
  input  logic             reset,
  m68k_bus_slave_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic as_s, uds_s, lds_s, rw_s;

  state_e           state_q,     state_d;
  logic             mem_req_q,   mem_req_d;
  logic             mem_we_q,    mem_we_d;
  logic [1:0]       mem_be_q,    mem_be_d;
  logic [22:0]      mem_addr_q,  mem_addr_d;
  logic [2:0]       mem_fc_q,    mem_fc_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic [15:0]      d_out_q,     d_out_d;
  logic             d_oe_q,      d_oe_d;
  logic             dtack_n_q,   dtack_n_d;
  logic             berr_n_q,    berr_n_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  // Address, fc and write data are sampled raw; only the strobes need synchronizing.
  m68k_sync #(
    .WIDTH (4)
  ) u_sync (
    .C100  (C100),
    .reset (reset),
    .d     ({bus.as_n, bus.uds_n, bus.lds_n, bus.rw_n}),
    .q     ({as_s, uds_s, lds_s, rw_s})
  );

  // Next-state and output decisions for one bus cycle.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_fc_d    = mem_fc_q;
    mem_wdata_d = mem_wdata_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    dtack_n_d   = dtack_n_q;
    berr_n_d    = berr_n_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (!as_s) begin
          if (bus.fc == FC_IACK) begin
            state_d = IGNORE;
          end else if (!uds_s || !lds_s) begin
            mem_addr_d  = bus.addr;
            mem_fc_d    = bus.fc;
            mem_we_d    = ~rw_s;
            mem_be_d    = byte_enables(uds_s, lds_s);
            mem_wdata_d = bus.d_in;
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            state_d     = REQ;
          end
          // AS low without a data strobe is the address-only phase: keep waiting.
        end
      end

      REQ: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            d_out_d = bus.mem_rdata;
          end
          d_oe_d    = ~mem_we_q;
          dtack_n_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Request is dropped for good; a late mem_ack falls outside REQ and is ignored.
          mem_req_d = 1'b0;
          berr_n_d  = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          d_oe_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      IGNORE: begin
        if (as_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any request in flight.
  always_ff @(posedge C100) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_fc_q    <= '0;
      mem_wdata_q <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_fc_q    <= mem_fc_d;
      mem_wdata_q <= mem_wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_fc    = mem_fc_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.dtack_n   = dtack_n_q;
  assign bus.berr_n    = berr_n_q;

endmodule

// File: tb/tb_m68k_bus_slave.sv
// Directed bench for m68k_bus_slave: reads, writes, timeout, IACK, reset mid-cycle.
module tb_m68k_bus_slave;

  logic C100;
  logic reset;
  int   n_tests;
  int   n_fail;

  m68k_bus_slave_if bus ();

  m68k_bus_slave #(
    .TIMEOUT (16)
  ) dut (
    .C100  (C100),
    .reset (reset),
    .bus   (bus)
  );

  initial C100 = 1'b0;
  always #5 C100 = ~C100;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge C100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negate AS and both data strobes, then look at the edge just before release takes effect.
  task automatic release_as(input string tag, input logic exp_dtack_n, input logic exp_berr_n);
    bus.as_n  = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    tick();
    tick();
    chk({tag, "_hold_dtack"}, 32'(bus.dtack_n), 32'(exp_dtack_n));
    chk({tag, "_hold_berr"},  32'(bus.berr_n),  32'(exp_berr_n));
  endtask

  // Full word read; the first edge also confirms the previous cycle has been released.
  task automatic read_cycle(input string tag, input logic [22:0] a, input logic [2:0] f,
                            input logic [15:0] rd, input int ack_wait);
    bus.addr  = a;
    bus.fc    = f;
    bus.rw_n  = 1'b1;
    bus.uds_n = 1'b0;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    tick();
    chk({tag, "_rel_dtack"}, 32'(bus.dtack_n), 32'd1);
    chk({tag, "_rel_doe"},   32'(bus.d_oe),    32'd0);
    chk({tag, "_req_k"},     32'(bus.mem_req), 32'd0);
    tick();
    chk({tag, "_req_k1"},    32'(bus.mem_req), 32'd0);
    tick();
    chk({tag, "_req_k2"},    32'(bus.mem_req), 32'd1);
    chk({tag, "_addr"},      32'(bus.mem_addr), 32'(a));
    chk({tag, "_be"},        32'(bus.mem_be),   32'd3);
    chk({tag, "_we"},        32'(bus.mem_we),   32'd0);
    chk({tag, "_fc"},        32'(bus.mem_fc),   32'(f));
    repeat (ack_wait) tick();
    chk({tag, "_req_wait"},  32'(bus.mem_req), 32'd1);
    chk({tag, "_dtack_wait"}, 32'(bus.dtack_n), 32'd1);
    bus.mem_rdata = rd;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    chk({tag, "_ack_req"},   32'(bus.mem_req), 32'd0);
    chk({tag, "_ack_dtack"}, 32'(bus.dtack_n), 32'd0);
    chk({tag, "_ack_dout"},  32'(bus.d_out),   32'(rd));
    chk({tag, "_ack_doe"},   32'(bus.d_oe),    32'd1);
    chk({tag, "_ack_berr"},  32'(bus.berr_n),  32'd1);
    tick();
    chk({tag, "_held_dout"}, 32'(bus.d_out),   32'(rd));
    chk({tag, "_held_dtack"}, 32'(bus.dtack_n), 32'd0);
    release_as(tag, 1'b0, 1'b1);
  endtask

  logic seen_req, seen_dtack, seen_berr;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset         = 1'b1;
    bus.as_n      = 1'b1;
    bus.rw_n      = 1'b1;
    bus.uds_n     = 1'b1;
    bus.lds_n     = 1'b1;
    bus.fc        = 3'd0;
    bus.addr      = '0;
    bus.d_in      = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req",   32'(bus.mem_req),  32'd0);
    chk("rst_dtack", 32'(bus.dtack_n),  32'd1);
    chk("rst_berr",  32'(bus.berr_n),   32'd1);
    chk("rst_doe",   32'(bus.d_oe),     32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_be",    32'(bus.mem_be),   32'd0);
    chk("rst_dout",  32'(bus.d_out),    32'd0);

    // Word read at byte 0x001000, fc=5, ack after 3 waiting cycles
    read_cycle("rd1", 23'h000800, 3'd5, 16'hBEEF, 3);

    // Lower-byte write at byte 0x002001, ack already high on the first REQ edge
    bus.addr  = 23'h001000;
    bus.fc    = 3'd1;
    bus.rw_n  = 1'b0;
    bus.d_in  = 16'h00A5;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    tick();
    chk("wr_rel_dtack", 32'(bus.dtack_n), 32'd1);
    chk("wr_rel_doe",   32'(bus.d_oe),    32'd0);
    tick();
    chk("wr_req_k1",    32'(bus.mem_req), 32'd0);
    tick();
    chk("wr_req",       32'(bus.mem_req),   32'd1);
    chk("wr_we",        32'(bus.mem_we),    32'd1);
    chk("wr_be",        32'(bus.mem_be),    32'd1);
    chk("wr_wdata",     32'(bus.mem_wdata), 32'h00A5);
    chk("wr_addr",      32'(bus.mem_addr),  32'h001000);
    chk("wr_fc",        32'(bus.mem_fc),    32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("wr_ack_dtack", 32'(bus.dtack_n), 32'd0);
    chk("wr_ack_req",   32'(bus.mem_req), 32'd0);
    chk("wr_ack_doe",   32'(bus.d_oe),    32'd0);
    chk("wr_ack_dout",  32'(bus.d_out),   32'hBEEF);
    release_as("wr", 1'b0, 1'b1);
    bus.rw_n = 1'b1;

    // No ack: BERR exactly 16 edges after mem_req rose, late ack ignored
    bus.addr  = 23'h001800;
    bus.fc    = 3'd6;
    bus.uds_n = 1'b0;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    tick();
    chk("to_rel_dtack", 32'(bus.dtack_n), 32'd1);
    tick();
    tick();
    chk("to_req",       32'(bus.mem_req), 32'd1);
    repeat (15) tick();
    chk("to_e15_berr",  32'(bus.berr_n),  32'd1);
    chk("to_e15_req",   32'(bus.mem_req), 32'd1);
    tick();
    chk("to_e16_berr",  32'(bus.berr_n),  32'd0);
    chk("to_e16_req",   32'(bus.mem_req), 32'd0);
    chk("to_e16_dtack", 32'(bus.dtack_n), 32'd1);
    chk("to_e16_doe",   32'(bus.d_oe),    32'd0);
    bus.mem_rdata = 16'h5A5A;
    bus.mem_ack   = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("to_late_dtack", 32'(bus.dtack_n), 32'd1);
    chk("to_late_req",   32'(bus.mem_req), 32'd0);
    chk("to_late_berr",  32'(bus.berr_n),  32'd0);
    chk("to_late_dout",  32'(bus.d_out),   32'hBEEF);
    release_as("to", 1'b1, 1'b0);

    // IACK cycle: nothing asserts even with mem_ack high
    bus.addr  = 23'h7FFFFF;
    bus.fc    = 3'b111;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    tick();
    chk("to_rel_berr", 32'(bus.berr_n), 32'd1);
    bus.mem_ack = 1'b1;
    seen_req   = 1'b0;
    seen_dtack = 1'b0;
    seen_berr  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_req   = seen_req   | bus.mem_req;
      seen_dtack = seen_dtack | ~bus.dtack_n;
      seen_berr  = seen_berr  | ~bus.berr_n;
    end
    bus.mem_ack = 1'b0;
    chk("iack_req",   32'(seen_req),   32'd0);
    chk("iack_dtack", 32'(seen_dtack), 32'd0);
    chk("iack_berr",  32'(seen_berr),  32'd0);
    release_as("iack", 1'b1, 1'b1);

    // Read after IACK (FSM must be back in IDLE), then reset while in REQ
    bus.addr  = 23'h000400;
    bus.fc    = 3'd5;
    bus.rw_n  = 1'b1;
    bus.uds_n = 1'b0;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    tick();
    tick();
    tick();
    chk("rr_req",  32'(bus.mem_req),  32'd1);
    chk("rr_addr", 32'(bus.mem_addr), 32'h000400);
    reset     = 1'b1;
    bus.as_n  = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_rst_req",   32'(bus.mem_req),  32'd0);
    chk("rr_rst_dtack", 32'(bus.dtack_n),  32'd1);
    chk("rr_rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rr_rst_dout",  32'(bus.d_out),    32'd0);
    read_cycle("rr_after", 23'h000500, 3'd2, 16'h1234, 0);

    // Back-to-back reads at bytes 0x000100 and 0x000102
    read_cycle("b2b_a", 23'h000080, 3'd5, 16'h1111, 1);
    read_cycle("b2b_b", 23'h000081, 3'd5, 16'h2222, 2);
    tick();
    chk("b2b_end_dtack", 32'(bus.dtack_n), 32'd1);
    chk("b2b_end_doe",   32'(bus.d_oe),    32'd0);
    chk("b2b_end_dout",  32'(bus.d_out),   32'h2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
